// File: rtl/irrigation_scheduler.sv
// -----------------------------------------------------------------------------
// irrigation_scheduler
//   Sequences the irrigation machine through fill / run / clean and shares its
//   single tank between a sprinkler requester and a drip requester, round-robin.
//   Each run is timed in Tick units and always ends with a clean cycle.
//
//   Optional feature: define ACK_WATCHDOG_EN to bound every wait for a machine
//   status acknowledge to ACK_TIMEOUT clock cycles (sticky Timeout flag).
//
// Ports
//   Clk, Rst_n          clock (rising edge), asynchronous active-low reset
//   Tick                1-cycle timebase enable used by the run timer
//   Req_asp, Req_got    sprinkler / drip requests (levels)
//   Enchendo .. Erro    machine status inputs (filling, full, sprinkler,
//                       drip, cleaning, error)
//   Bs, Vs, L           sprinkler / drip / clean commands to the machine
//   Grant_asp/got       requester currently owns the tank
//   Busy, Done, Fault   not idle / 1-cycle run-complete pulse / in fault
//   Timeout             sticky watchdog flag (constant 0 without the macro)
//   Remaining           Ticks left in the current run, 0 outside RUN
// -----------------------------------------------------------------------------
module irrigation_scheduler #(
    parameter int TW          = 8,
    parameter int ASP_TICKS   = 10,
    parameter int GOT_TICKS   = 20,
    parameter int ACK_TIMEOUT = 16
) (
    input  logic          Clk,
    input  logic          Rst_n,
    input  logic          Tick,
    input  logic          Req_asp,
    input  logic          Req_got,
    input  logic          Enchendo,
    input  logic          Cheio,
    input  logic          Aspersao,
    input  logic          Gotejamento,
    input  logic          Limpando,
    input  logic          Erro,
    output logic          Bs,
    output logic          Vs,
    output logic          L,
    output logic          Grant_asp,
    output logic          Grant_got,
    output logic          Busy,
    output logic          Done,
    output logic          Fault,
    output logic          Timeout,
    output logic [TW-1:0] Remaining
);

    typedef enum logic [2:0] {
        S_IDLE, S_WAIT_FULL, S_GNT, S_RUN, S_STOP, S_CLEAN, S_FAULT
    } state_t;

    // A zero-length run would never see Remaining==1, so it is stretched to 1.
    localparam logic [TW-1:0] ASP_LEN = (ASP_TICKS == 0) ? TW'(1) : TW'(ASP_TICKS);
    localparam logic [TW-1:0] GOT_LEN = (GOT_TICKS == 0) ? TW'(1) : TW'(GOT_TICKS);

    state_t        state_q, state_d;
    logic          owner_got_q, owner_got_d;   // 1: drip owns the tank
    logic          last_got_q, last_got_d;     // rr pointer, 1: drip granted last
    logic [TW-1:0] rem_q, rem_d;
    logic          done_q, done_d;
    logic          bs_q, bs_d, vs_q, vs_d, l_q, l_d;
    logic          gnt_asp_q, gnt_asp_d, gnt_got_q, gnt_got_d;
    logic          busy_q, busy_d, fault_q, fault_d;
    logic          ack;
    logic          run_cmd, owns_tank;

`ifdef ACK_WATCHDOG_EN
    localparam int WDW = $clog2(ACK_TIMEOUT + 1);
    localparam logic [WDW-1:0] WD_LAST = WDW'(ACK_TIMEOUT - 1);
    logic [WDW-1:0] wd_q, wd_d;
    logic           timeout_q, timeout_d;
    logic           waiting;
`endif

    always_comb begin
        // NOTE: every variable gets a default before any branch, so no path
        // leaves one unassigned and no latch is inferred.
        state_d     = state_q;
        owner_got_d = owner_got_q;
        last_got_d  = last_got_q;
        rem_d       = rem_q;
        done_d      = 1'b0;
        ack         = owner_got_q ? Gotejamento : Aspersao;
`ifdef ACK_WATCHDOG_EN
        wd_d        = '0;
        timeout_d   = timeout_q;
        waiting     = (state_q == S_WAIT_FULL) || (state_q == S_GNT) ||
                      (state_q == S_STOP)      || (state_q == S_CLEAN);
`endif

        if (Erro && (state_q != S_IDLE) && (state_q != S_FAULT)) begin
            state_d    = S_FAULT;
            // Undo the grant so the interrupted requester is served first.
            last_got_d = !owner_got_q;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (!Erro && (Req_asp || Req_got)) begin
                        // Drip wins only if asp is absent or asp was served last.
                        owner_got_d = Req_got && (!Req_asp || !last_got_q);
                        last_got_d  = owner_got_d;
                        state_d     = S_WAIT_FULL;
                    end
                end
                S_WAIT_FULL: if (Cheio) state_d = S_GNT;
                S_GNT: begin
                    // Loading here means a Tick in this cycle is never counted.
                    if (ack) begin
                        state_d = S_RUN;
                        rem_d   = owner_got_q ? GOT_LEN : ASP_LEN;
                    end
                end
                S_RUN: begin
                    if (Tick) begin
                        if (rem_q == TW'(1)) state_d = S_STOP;
                        else                 rem_d   = rem_q - TW'(1);
                    end
                end
                S_STOP:  if (Limpando) state_d = S_CLEAN;
                S_CLEAN: begin
                    if (!Limpando && Enchendo) begin
                        state_d = S_IDLE;
                        done_d  = 1'b1;
                    end
                end
                S_FAULT: if (!Erro) state_d = S_IDLE;
                default: state_d = S_IDLE;
            endcase
`ifdef ACK_WATCHDOG_EN
            // Cycle count restarts on every state change.
            if (waiting && (state_d == state_q)) begin
                if (wd_q == WD_LAST) begin
                    state_d    = S_FAULT;
                    timeout_d  = 1'b1;
                    last_got_d = !owner_got_q;
                end else begin
                    wd_d = wd_q + WDW'(1);
                end
            end
`endif
        end

        if (state_d != S_RUN) rem_d = '0;

        // Outputs are decoded from the next state so they register in step.
        run_cmd   = (state_d == S_GNT) || (state_d == S_RUN);
        owns_tank = (state_d != S_IDLE) && (state_d != S_FAULT);
        bs_d      = run_cmd && !owner_got_d;
        vs_d      = run_cmd && owner_got_d;
        l_d       = (state_d == S_STOP);
        gnt_asp_d = owns_tank && !owner_got_d;
        gnt_got_d = owns_tank && owner_got_d;
        busy_d    = (state_d != S_IDLE);
        fault_d   = (state_d == S_FAULT);
    end

    // NOTE: sequential state uses non-blocking assignments only, so every flop
    // samples pre-edge values regardless of process ordering.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state_q     <= S_IDLE;
            owner_got_q <= 1'b0;
            last_got_q  <= 1'b1;
            rem_q       <= '0;
            done_q      <= 1'b0;
            bs_q        <= 1'b0;
            vs_q        <= 1'b0;
            l_q         <= 1'b0;
            gnt_asp_q   <= 1'b0;
            gnt_got_q   <= 1'b0;
            busy_q      <= 1'b0;
            fault_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            owner_got_q <= owner_got_d;
            last_got_q  <= last_got_d;
            rem_q       <= rem_d;
            done_q      <= done_d;
            bs_q        <= bs_d;
            vs_q        <= vs_d;
            l_q         <= l_d;
            gnt_asp_q   <= gnt_asp_d;
            gnt_got_q   <= gnt_got_d;
            busy_q      <= busy_d;
            fault_q     <= fault_d;
        end
    end

`ifdef ACK_WATCHDOG_EN
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            wd_q      <= '0;
            timeout_q <= 1'b0;
        end else begin
            wd_q      <= wd_d;
            timeout_q <= timeout_d;
        end
    end
    assign Timeout = timeout_q;
`else
    assign Timeout = 1'b0;
`endif

    assign Bs        = bs_q;
    assign Vs        = vs_q;
    assign L         = l_q;
    assign Grant_asp = gnt_asp_q;
    assign Grant_got = gnt_got_q;
    assign Busy      = busy_q;
    assign Done      = done_q;
    assign Fault     = fault_q;
    assign Remaining = rem_q;

endmodule

// File: tb/tb_irrigation_scheduler.sv
// -----------------------------------------------------------------------------
// tb_irrigation_scheduler
//   Directed bench for irrigation_scheduler. The main instance uses default
//   parameters; a second instance with ASP_TICKS=0 shares the inputs and is
//   examined only in test_tick_edges. Flags vector order:
//   {Bs, Vs, L, Grant_asp, Grant_got, Busy, Done, Fault}.
// -----------------------------------------------------------------------------
module tb_irrigation_scheduler;

    logic clk = 1'b0;
    logic rst_n;
    logic tick, req_asp, req_got, enchendo, cheio, aspersao, gotejamento, limpando, erro;
    logic bs, vs, l, grant_asp, grant_got, busy, done, fault, timeout;
    logic [7:0] remaining;
    logic d0_bs, d0_vs, d0_l, d0_ga, d0_gg, d0_busy, d0_done, d0_fault, d0_to;
    logic [7:0] d0_rem;
    logic [7:0] flags;

    int tests_run    = 0;
    int tests_failed = 0;

    always #5 clk = ~clk;

    assign flags = {bs, vs, l, grant_asp, grant_got, busy, done, fault};

    irrigation_scheduler u_dut (
        .Clk(clk), .Rst_n(rst_n), .Tick(tick), .Req_asp(req_asp), .Req_got(req_got),
        .Enchendo(enchendo), .Cheio(cheio), .Aspersao(aspersao), .Gotejamento(gotejamento),
        .Limpando(limpando), .Erro(erro), .Bs(bs), .Vs(vs), .L(l),
        .Grant_asp(grant_asp), .Grant_got(grant_got), .Busy(busy), .Done(done),
        .Fault(fault), .Timeout(timeout), .Remaining(remaining)
    );

    irrigation_scheduler #(.ASP_TICKS(0)) u_dut0 (
        .Clk(clk), .Rst_n(rst_n), .Tick(tick), .Req_asp(req_asp), .Req_got(req_got),
        .Enchendo(enchendo), .Cheio(cheio), .Aspersao(aspersao), .Gotejamento(gotejamento),
        .Limpando(limpando), .Erro(erro), .Bs(d0_bs), .Vs(d0_vs), .L(d0_l),
        .Grant_asp(d0_ga), .Grant_got(d0_gg), .Busy(d0_busy), .Done(d0_done),
        .Fault(d0_fault), .Timeout(d0_to), .Remaining(d0_rem)
    );

    // Invariants checked every cycle out of reset.
    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            tests_run++;
            if ((int'(bs) + int'(vs) + int'(l)) > 1 || (done && fault)) begin
                tests_failed++;
                $display("FAIL exclusivity: flags=%b required Bs/Vs/L one-hot-or-zero and not Done&Fault", flags);
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL global_time_limit: bench did not finish");
        $fatal(1, "time limit");
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        {tick, req_asp, req_got, enchendo, cheio, aspersao, gotejamento, limpando, erro} = '0;
        cyc();
        cyc();
        rst_n = 1'b1;
        cyc();
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        {tick, req_asp, req_got, enchendo, cheio, aspersao, gotejamento, limpando, erro} = '0;
        cyc();
        tests_run++;
        if ({flags, timeout, remaining} !== 17'd0) begin
            tests_failed++;
            $display("FAIL reset_outputs: got flags=%b to=%b rem=%0d required all 0", flags, timeout, remaining);
        end
        rst_n = 1'b1;
        cyc();
        tests_run++;
        if ({flags, timeout, remaining} !== 17'd0) begin
            tests_failed++;
            $display("FAIL post_reset_idle: got flags=%b rem=%0d required all 0", flags, remaining);
        end
    endtask

    // One complete run starting from IDLE with the request(s) already applied.
    task automatic run_one(input bit got, input int n, input bit drop_req, input string nm);
        logic ga, gg;
        ga = !got;
        gg = got;
        cyc();
        if (drop_req) begin req_asp = 1'b0; req_got = 1'b0; end
        tests_run++;
        if (flags !== {3'b000, ga, gg, 3'b100}) begin
            tests_failed++;
            $display("FAIL %s_wait_full: got %b required %b", nm, flags, {3'b000, ga, gg, 3'b100});
        end
        cheio = 1'b1; cyc(); cheio = 1'b0;
        tests_run++;
        if (flags !== {ga, gg, 1'b0, ga, gg, 3'b100}) begin
            tests_failed++;
            $display("FAIL %s_gnt: got %b required %b", nm, flags, {ga, gg, 1'b0, ga, gg, 3'b100});
        end
        if (got) gotejamento = 1'b1; else aspersao = 1'b1;
        cyc();
        tests_run++;
        if (remaining !== 8'(n) || flags !== {ga, gg, 1'b0, ga, gg, 3'b100}) begin
            tests_failed++;
            $display("FAIL %s_run_entry: got rem=%0d flags=%b required rem=%0d", nm, remaining, flags, n);
        end
        for (int k = 1; k <= n; k++) begin
            if (got) begin
                cyc();   // no Tick: Remaining must hold
                tests_run++;
                if (remaining !== 8'(n - k + 1)) begin
                    tests_failed++;
                    $display("FAIL %s_hold: got rem=%0d required %0d", nm, remaining, n - k + 1);
                end
            end
            tick = 1'b1; cyc(); tick = 1'b0;
            tests_run++;
            if (remaining !== 8'(n - k) || (k < n && (bs !== ga || vs !== gg))) begin
                tests_failed++;
                $display("FAIL %s_tick%0d: got rem=%0d bs=%b vs=%b required rem=%0d", nm, k, remaining, bs, vs, n - k);
            end
        end
        tests_run++;
        if (flags !== {3'b001, ga, gg, 3'b100}) begin
            tests_failed++;
            $display("FAIL %s_stop: got %b required %b", nm, flags, {3'b001, ga, gg, 3'b100});
        end
        aspersao = 1'b0; gotejamento = 1'b0;
        limpando = 1'b1; cyc(); limpando = 1'b0;
        tests_run++;
        if (flags !== {3'b000, ga, gg, 3'b100}) begin
            tests_failed++;
            $display("FAIL %s_clean: got %b required %b", nm, flags, {3'b000, ga, gg, 3'b100});
        end
        enchendo = 1'b1; cyc(); enchendo = 1'b0;
        tests_run++;
        if (flags !== 8'b0000_0010) begin
            tests_failed++;
            $display("FAIL %s_done: got %b required 00000010", nm, flags);
        end
    endtask

    task automatic test_single_asp();
        apply_reset();
        req_asp = 1'b1;
        run_one(1'b0, 10, 1'b1, "single_asp");
        cyc();
        tests_run++;
        if (flags !== 8'b0) begin
            tests_failed++;
            $display("FAIL single_asp_done_pulse: got %b required 00000000", flags);
        end
    endtask

    task automatic test_back_to_back();
        apply_reset();
        req_asp = 1'b1;
        req_got = 1'b1;
        run_one(1'b0, 10, 1'b0, "rr_first_asp");
        run_one(1'b1, 20, 1'b0, "rr_second_got");
        run_one(1'b0, 10, 1'b1, "rr_third_asp");
    endtask

    task automatic test_fault_regrant();
        apply_reset();
        req_got = 1'b1;
        cyc();
        cheio = 1'b1; cyc(); cheio = 1'b0;
        gotejamento = 1'b1; cyc();
        for (int k = 0; k < 16; k++) begin tick = 1'b1; cyc(); tick = 1'b0; end
        tests_run++;
        if (remaining !== 8'd4 || vs !== 1'b1) begin
            tests_failed++;
            $display("FAIL fault_setup: got rem=%0d vs=%b required rem=4 vs=1", remaining, vs);
        end
        erro = 1'b1; cyc(); gotejamento = 1'b0;
        tests_run++;
        if (flags !== 8'b0000_0101 || remaining !== 8'd0) begin
            tests_failed++;
            $display("FAIL fault_entry: got flags=%b rem=%0d required 00000101 rem=0", flags, remaining);
        end
        cyc();
        tests_run++;
        if (flags !== 8'b0000_0101) begin
            tests_failed++;
            $display("FAIL fault_hold: got %b required 00000101", flags);
        end
        erro = 1'b0; req_asp = 1'b1; cyc();
        tests_run++;
        if (flags !== 8'b0) begin
            tests_failed++;
            $display("FAIL fault_exit: got %b required 00000000", flags);
        end
        cyc();
        tests_run++;
        if (flags !== 8'b0000_1100) begin
            tests_failed++;
            $display("FAIL fault_regrant_got: got %b required 00001100", flags);
        end
        cheio = 1'b1; cyc(); cheio = 1'b0;
        gotejamento = 1'b1; cyc();
        tests_run++;
        if (remaining !== 8'd20 || vs !== 1'b1) begin
            tests_failed++;
            $display("FAIL fault_regrant_len: got rem=%0d vs=%b required rem=20 vs=1", remaining, vs);
        end
    endtask

    task automatic test_idle_erro_block();
        apply_reset();
        erro = 1'b1;
        req_asp = 1'b1;
        repeat (3) cyc();
        tests_run++;
        if (flags !== 8'b0) begin
            tests_failed++;
            $display("FAIL idle_erro_block: got %b required 00000000", flags);
        end
        erro = 1'b0; cyc();
        tests_run++;
        if (flags !== 8'b0001_0100) begin
            tests_failed++;
            $display("FAIL idle_erro_release: got %b required 00010100", flags);
        end
    endtask

    task automatic test_tick_edges();
        apply_reset();
        req_asp = 1'b1; cyc(); req_asp = 1'b0;
        cheio = 1'b1; cyc(); cheio = 1'b0;
        aspersao = 1'b1;
        tick = 1'b1;   // coincides with the GNT->RUN edge and stays high
        cyc();
        tests_run++;
        if (remaining !== 8'd10 || d0_rem !== 8'd1) begin
            tests_failed++;
            $display("FAIL tick_entry: got rem=%0d d0_rem=%0d required 10 and 1", remaining, d0_rem);
        end
        for (int k = 1; k <= 10; k++) begin
            cyc();
            tests_run++;
            if (remaining !== 8'(10 - k)) begin
                tests_failed++;
                $display("FAIL tick_every_%0d: got rem=%0d required %0d", k, remaining, 10 - k);
            end
            if (k == 1) begin
                tests_run++;
                if (d0_rem !== 8'd0 || d0_l !== 1'b1 || d0_bs !== 1'b0) begin
                    tests_failed++;
                    $display("FAIL zero_len_run: got rem=%0d l=%b bs=%b required 0 1 0", d0_rem, d0_l, d0_bs);
                end
            end
            if (k == 9) begin
                tests_run++;
                if (bs !== 1'b1 || l !== 1'b0) begin
                    tests_failed++;
                    $display("FAIL tick_last_run: got bs=%b l=%b required 1 0", bs, l);
                end
            end
        end
        tick = 1'b0;
        tests_run++;
        if (l !== 1'b1 || bs !== 1'b0) begin
            tests_failed++;
            $display("FAIL tick_stop: got l=%b bs=%b required 1 0", l, bs);
        end
    endtask

    task automatic test_watchdog();
        apply_reset();
        req_asp = 1'b1; cyc(); req_asp = 1'b0;
        cheio = 1'b1; cyc(); cheio = 1'b0;   // now in GNT, Aspersao held 0
`ifdef ACK_WATCHDOG_EN
        for (int i = 1; i < 16; i++) begin
            cyc();
            tests_run++;
            if (fault !== 1'b0 || bs !== 1'b1 || timeout !== 1'b0) begin
                tests_failed++;
                $display("FAIL wd_early_%0d: got fault=%b bs=%b to=%b required 0 1 0", i, fault, bs, timeout);
            end
        end
        cyc();
        tests_run++;
        if (fault !== 1'b1 || timeout !== 1'b1 || bs !== 1'b0) begin
            tests_failed++;
            $display("FAIL wd_fire: got fault=%b to=%b bs=%b required 1 1 0", fault, timeout, bs);
        end
        cyc();
        tests_run++;
        if (fault !== 1'b0 || busy !== 1'b0 || timeout !== 1'b1) begin
            tests_failed++;
            $display("FAIL wd_sticky: got fault=%b busy=%b to=%b required 0 0 1", fault, busy, timeout);
        end
        apply_reset();
        tests_run++;
        if (timeout !== 1'b0) begin
            tests_failed++;
            $display("FAIL wd_reset_clear: got to=%b required 0", timeout);
        end
`else
        repeat (20) cyc();
        tests_run++;
        if (fault !== 1'b0 || bs !== 1'b1 || timeout !== 1'b0) begin
            tests_failed++;
            $display("FAIL no_wd_wait: got fault=%b bs=%b to=%b required 0 1 0", fault, bs, timeout);
        end
`endif
    endtask

    task automatic test_reset_mid_run();
        apply_reset();
        req_asp = 1'b1; cyc(); req_asp = 1'b0;
        cheio = 1'b1; cyc(); cheio = 1'b0;
        aspersao = 1'b1; cyc();
        repeat (3) begin tick = 1'b1; cyc(); tick = 1'b0; end
        tests_run++;
        if (remaining !== 8'd7 || bs !== 1'b1) begin
            tests_failed++;
            $display("FAIL rst_setup: got rem=%0d bs=%b required 7 1", remaining, bs);
        end
        #2 rst_n = 1'b0;
        #1;
        tests_run++;
        if (bs !== 1'b0 || grant_asp !== 1'b0 || remaining !== 8'd0 || busy !== 1'b0) begin
            tests_failed++;
            $display("FAIL rst_async: got bs=%b ga=%b rem=%0d busy=%b required all 0", bs, grant_asp, remaining, busy);
        end
        aspersao = 1'b0;
        cyc();
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            cyc();
            tests_run++;
            if (flags !== 8'b0) begin
                tests_failed++;
                $display("FAIL rst_release_%0d: got %b required 00000000", i, flags);
            end
        end
    endtask

    initial begin
        test_reset();
        test_single_asp();
        test_back_to_back();
        test_fault_regrant();
        test_idle_erro_block();
        test_tick_edges();
        test_watchdog();
        test_reset_mid_run();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
